sd_rx_bd_fifo: RTL and testbench

SD_RX_BD_FIFO -- requirements
Module: sd_rx_bd_fifo

---
 rtl/sd_rx_bd_fifo.sv | 89 ++++++++
 tb/tb_sd_rx_bd_fifo.sv | 134 +++++++++++++
 2 files changed

// File: rtl/sd_rx_bd_fifo.sv
// sd_rx_bd_fifo: circular buffer of 4-halfword receive buffer descriptors
// between a bus master writer and an SD-side reader.
//
// Ports:
//   wb_clk_i   clock, all logic on its rising edge
//   wb_rst_i   asynchronous active-high reset
//   we_m       master write strobe, one halfword per high cycle
//   dat_in_m   master write data
//   re_s       SD-side read request, one halfword per high cycle
//   dat_out_s  registered read data
//   ack_o_s    read data valid, one cycle after an accepted read
//   clr_i      synchronous clear, overrides we_m/re_s
//   free_bd    number of free descriptor slots
//   err_o      bit0 overflow, bit1 underflow (sticky)
//
// Build option: define SD_BD_ERR_FLAGS_EN to enable the err_o flags;
// otherwise err_o is tied to 0.
module sd_rx_bd_fifo #(
    parameter int BD_DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        we_m,
    input  logic [15:0] dat_in_m,
    input  logic        re_s,
    output logic [15:0] dat_out_s,
    output logic        ack_o_s,
    input  logic        clr_i,
    output logic [7:0]  free_bd,
    output logic [1:0]  err_o
);
    localparam int AW = $clog2(4 * BD_DEPTH);

    typedef enum logic {IDLE, ACK} state_t;

    logic [15:0]   mem [4*BD_DEPTH];
    logic [AW-1:0] wptr, rptr;
    state_t        state, state_nxt;
    logic          wr_ok, rd_ok, wr_done, rd_done;

    // Reads are gated by completed descriptors only, so a partial
    // descriptor is never visible to the reader.
    always_comb begin
        wr_ok     = we_m && free_bd != 8'd0 && !clr_i;
        rd_ok     = re_s && free_bd != 8'(BD_DEPTH) && !clr_i;
        wr_done   = wr_ok && wptr[1:0] == 2'd3;
        rd_done   = rd_ok && rptr[1:0] == 2'd3;
        state_nxt = rd_ok ? ACK : IDLE;
        ack_o_s   = state == ACK;
    end

    always_ff @(posedge wb_clk_i)
        if (wr_ok) mem[wptr] <= dat_in_m;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wptr      <= '0;
            rptr      <= '0;
            free_bd   <= 8'(BD_DEPTH);
            dat_out_s <= '0;
            state     <= IDLE;
        end else begin
            state <= state_nxt;
            if (clr_i) begin
                wptr    <= '0;
                rptr    <= '0;
                free_bd <= 8'(BD_DEPTH);
            end else begin
                if (wr_ok) wptr <= wptr + 1'b1;
                if (rd_ok) begin
                    rptr      <= rptr + 1'b1;
                    dat_out_s <= mem[rptr];
                end
                // Simultaneous completions cancel out.
                if (wr_done != rd_done) free_bd <= wr_done ? free_bd - 8'd1 : free_bd + 8'd1;
            end
        end
    end

`ifdef SD_BD_ERR_FLAGS_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) err_o <= 2'b00;
        else if (clr_i) err_o <= 2'b00;
        else err_o <= err_o | {re_s && !rd_ok, we_m && !wr_ok};
    end
`else
    assign err_o = 2'b00;
`endif
endmodule

// File: tb/tb_sd_rx_bd_fifo.sv
// tb_sd_rx_bd_fifo: scoreboard bench for sd_rx_bd_fifo.
module tb_sd_rx_bd_fifo;
    logic        wb_clk_i = 0, wb_rst_i = 0;
    logic        we_m = 0, re_s = 0, clr_i = 0;
    logic [15:0] dat_in_m = 0;
    logic [15:0] dat_out_s;
    logic        ack_o_s;
    logic [7:0]  free_bd;
    logic [1:0]  err_o;

`ifdef SD_BD_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int checks = 0, errors = 0;
    logic [15:0] data_q[$];
    logic [15:0] exp_q[$];
    int mfree = 8, wcnt = 0, rcnt = 0;
    logic [1:0] merr = 2'b00;

    sd_rx_bd_fifo #(.BD_DEPTH(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .we_m(we_m), .dat_in_m(dat_in_m),
        .re_s(re_s), .dat_out_s(dat_out_s), .ack_o_s(ack_o_s), .clr_i(clr_i),
        .free_bd(free_bd), .err_o(err_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        data_q.delete();
        mfree = 8;
        wcnt = 0;
        rcnt = 0;
        merr = 2'b00;
    endtask

    task automatic step(input logic w, input logic [15:0] d, input logic r, input logic c);
        logic wok, rok;
        logic [15:0] e;
        @(negedge wb_clk_i);
        we_m = w; dat_in_m = d; re_s = r; clr_i = c;
        wok = w && mfree > 0 && !c;
        rok = r && mfree < 8 && !c;
        if (c) model_clear();
        else begin
            if (ERR_EN) merr = merr | {r && !rok, w && !wok};
            if (rok) begin
                exp_q.push_back(data_q.pop_front());
                rcnt++;
                if (rcnt % 4 == 0) mfree++;
            end
            if (wok) begin
                data_q.push_back(d);
                wcnt++;
                if (wcnt % 4 == 0) mfree--;
            end
        end
        @(posedge wb_clk_i);
        #1;
        check("ack", {15'd0, ack_o_s}, {15'd0, rok});
        if (ack_o_s) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
            check("dat_out_s", dat_out_s, e);
        end else if (rok && exp_q.size() > 0) void'(exp_q.pop_front());
        check("free_bd", {8'd0, free_bd}, 16'(mfree));
        check("err_o", {14'd0, err_o}, {14'd0, merr});
    endtask

    task automatic do_reset();
        @(negedge wb_clk_i);
        we_m = 0; re_s = 0; clr_i = 0;
        wb_rst_i = 1;
        #1;
        check("rst_free_bd", {8'd0, free_bd}, 16'd8);
        check("rst_ack", {15'd0, ack_o_s}, 16'd0);
        check("rst_dat_out_s", dat_out_s, 16'd0);
        check("rst_err_o", {14'd0, err_o}, 16'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 0;
        model_clear();
        exp_q.delete();
    endtask

    initial begin
        do_reset();
        // one descriptor in, then out
        step(1, 16'h1000, 0, 0);
        step(1, 16'h0000, 0, 0);
        step(1, 16'h0020, 0, 0);
        step(1, 16'h0000, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        // fill completely, then overflow
        for (int i = 0; i < 32; i++) step(1, 16'($urandom), 0, 0);
        step(1, 16'hDEAD, 0, 0);
        for (int i = 0; i < 32; i++) step(0, 0, 1, 0);
        // underflow, then clear (also with concurrent strobes)
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        step(1, 16'hBEEF, 1, 1);
        // completing write coincident with completing read
        for (int i = 0; i < 4; i++) step(1, 16'h0100 + 16'(i), 0, 0);
        for (int i = 0; i < 3; i++) step(1, 16'h0200 + 16'(i), 1, 0);
        step(1, 16'h0203, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        // pointer wrap: slot 0 revisited carries 0xA5A5
        step(0, 0, 0, 1);
        for (int i = 0; i < 48; i++) step(1, i == 32 ? 16'hA5A5 : 16'($urandom), i % 3 != 0, 0);
        for (int i = 0; i < 24; i++) step(0, 0, 1, 0);
        // reset mid-descriptor
        step(0, 0, 0, 1);
        step(1, 16'h1111, 0, 0);
        step(1, 16'h2222, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 16'h3330 + 16'(i), 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        // random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 40) == 0);
        step(0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
